oflow_core_fsm_cr: RTL
======================

Name: oflow_core_fsm_cr

Overview:
- Conflict-resolution sequencer for the core. Runs after registration, when every PE has posted a candidate ID and similarity score for its bbox into the score board.
- Detects candidate IDs claimed by more than one bbox. The highest score keeps the ID; every loser gets a fresh ID.
- Writes final IDs back through the score-board write port, then reports done_cr and conflict_counter_th to oflow_core_fsm_top.

Parameters:
- PE_NUM, 24, PEs per score-board row.
- MAX_ROWS, 11, score-board rows (ceil(256/24)).
- MAX_BBOX, 256, max bboxes per frame.
- ID_W, 8, ID width. ID 0 means "no match".
- SCORE_W, 16, unsigned similarity score width; larger is better.

Ports:
- clk  in  1  clock.
- reset_N  in  1  asynchronous active-low reset.
- start_cr  in  1  single-cycle start pulse from oflow_core_fsm_top.
- num_of_bbox_in_frame  in  9  bboxes in the current frame, 0..256.
- conflict_th  in  8  conflict threshold from the reg file; 0 disables the flag.
- first_free_id  in  ID_W  first unused ID; sampled at start_cr.
- sb_rd_en  out  1  score-board read strobe.
- sb_row_sel  out  4  read/write row.
- sb_pe_sel  out  5  read/write column.
- sb_id_in  in  ID_W  candidate ID; valid 1 cycle after sb_rd_en.
- sb_score_in  in  SCORE_W  candidate score; same timing as sb_id_in.
- id_wr_en  out  1  final-ID write strobe.
- id_wr_data  out  ID_W  final ID.
- next_free_id  out  ID_W  first unused ID after this frame.
- conflict_count  out  9  conflicts found in the last run.
- conflict_counter_th  out  1  conflict_count >= conflict_th, with conflict_th != 0.
- busy  out  1  high in every state except IDLE.
- done_cr  out  1  single-cycle completion pulse.

Behaviour:
- Reset: state IDLE. All outputs 0, all counters 0, ownership-table valid bits and loser vector cleared.
- Index mapping: bbox i maps to row = i / PE_NUM, pe = i % PE_NUM. These come from a pe counter that wraps at PE_NUM-1 and increments row; no dividers.
- IDLE
  - start_cr: latch N and first_free_id into new_id_ctr; clear conflict_count, conflict_counter_th, loser vector and table valid bits in that cycle.
  - If N == 0, go to DONE; otherwise go to SCAN_RD.
  - start_cr in any other state is ignored.
- SCAN_RD: sb_rd_en = 1 at (row, pe) for index i. Next state SCAN_CMP.
- SCAN_CMP (read data valid), with id = sb_id_in, score = sb_score_in:
  - id == 0: set loser[i]; this is not counted as a conflict.
  - Table[id] invalid: store {owner = i, score}.
  - Table[id] valid and score > table score: set loser[owner]; replace entry with {i, score}; conflict_count += 1.
  - Table[id] valid and score <= table score: set loser[i]; conflict_count += 1. On a tie the incumbent (lower index) wins.
  - Then i += 1. If i == N, reset i/row/pe to 0 and go to WB_RD; otherwise go to SCAN_RD.
- WB_RD: sb_rd_en = 1 at index i. Next state WB_WR.
- WB_WR:
  - id_wr_en = 1 at the same row/pe.
  - id_wr_data = new_id_ctr if loser[i], else sb_id_in.
  - new_id_ctr increments when loser[i] is set. It wraps modulo 2^ID_W, skipping 0: 255 goes to 1.
  - Then i += 1. If i == N, go to DONE; otherwise go to WB_RD.
- DONE:
  - done_cr = 1 for one cycle.
  - conflict_counter_th <= (conflict_th != 0) && (conflict_count >= conflict_th).
  - next_free_id <= new_id_ctr.
  - Next state IDLE.
- conflict_counter_th and conflict_count hold until the next start_cr.
- Latency: 4N + 2 cycles from start_cr to done_cr. N = 0 gives 2 cycles.
- Output timing: sb_* and id_wr_* are registered state decodes; row/pe are stable while strobes are high.
- Reset mid-run: immediate return to IDLE. No done_cr; all partial results discarded.
- conflict_count saturates at 511.

Decomposition:
- Shared package oflow_cr_pkg:
  - state enum {IDLE, SCAN_RD, SCAN_CMP, WB_RD, WB_WR, DONE};
  - owner-entry struct {valid, owner[7:0], score[SCORE_W-1:0]};
  - PE_NUM, MAX_ROWS, MAX_BBOX constants, shared with oflow_core_define.
- Sub-module oflow_cr_owner_table:
  - 2^ID_W entries, one combinational read port and one write port;
  - single-cycle clear of all valid bits.
- The FSM, counters and loser vector stay in the top module.

Test Plan:
- N=3, IDs {5,6,7}, scores {10,20,30} -> writes 5,6,7; conflict_count=0; done_cr at cycle 14; next_free_id=first_free_id=40.
- N=3, IDs {5,5,5}, scores {10,30,20}, first_free_id=40 -> writes 40,5,41; conflict_count=2; next_free_id=42.
- Tie: N=2, IDs {9,9}, scores {50,50}, free=40 -> writes 9,40; conflict_count=1.
- IDs {0,3}, free=255 -> writes 255,3; conflict_count=0; next_free_id=1 (0 skipped).
- N=0 with start_cr -> done_cr 2 cycles later; no sb_rd_en; no id_wr_en.
- N=26, all ID 4, scores increasing, conflict_th=20 -> conflict_count=25; conflict_counter_th=1; bbox 24 read at row 1 pe 0.
- reset_N low at cycle 5 of that N=26 run -> busy=0 and no done_cr; a fresh start_cr re-runs cleanly.

Source files
------------

// File: rtl/oflow_cr_pkg.sv
// Shared definitions for the conflict-resolution sequencer.
//   - geometry constants (PE_NUM, MAX_ROWS, MAX_BBOX) and derived widths
//   - FSM state enum and the ownership-table entry struct
//   - id_inc(): next free ID, wrapping modulo 2^ID_W and skipping ID 0
package oflow_cr_pkg;

    localparam int PE_NUM    = 24;
    localparam int MAX_ROWS  = 11;
    localparam int MAX_BBOX  = 256;
    localparam int ID_W      = 8;
    localparam int SCORE_W   = 16;

    localparam int ROW_W     = $clog2(MAX_ROWS);
    localparam int PE_W      = $clog2(PE_NUM);
    localparam int CNT_W     = $clog2(MAX_BBOX + 1);
    localparam int TBL_DEPTH = 1 << ID_W;

    typedef enum logic [2:0] {
        IDLE,
        SCAN_RD,
        SCAN_CMP,
        WB_RD,
        WB_WR,
        DONE
    } cr_state_e;

    typedef struct packed {
        logic               valid;
        logic [7:0]         owner;
        logic [SCORE_W-1:0] score;
    } owner_entry_t;

    // ID 0 means "no match", so it is never handed out as a fresh ID.
    function automatic logic [ID_W-1:0] id_inc(input logic [ID_W-1:0] id);
        return (id == '1) ? ID_W'(1) : id + ID_W'(1);
    endfunction

endpackage

// File: rtl/oflow_core_fsm_cr_if.sv
// Score-board access bus between the sequencer and the score board.
//   sb_rd_en/sb_row_sel/sb_pe_sel : read strobe and (row, pe) address
//   sb_id_in/sb_score_in          : read data, valid one cycle after sb_rd_en
//   id_wr_en/id_wr_data           : final-ID write, same (row, pe) address
// master = sequencer side, slave = score-board side.
interface oflow_core_fsm_cr_if;
    import oflow_cr_pkg::*;

    logic               sb_rd_en;
    logic [ROW_W-1:0]   sb_row_sel;
    logic [PE_W-1:0]    sb_pe_sel;
    logic [ID_W-1:0]    sb_id_in;
    logic [SCORE_W-1:0] sb_score_in;
    logic               id_wr_en;
    logic [ID_W-1:0]    id_wr_data;

    modport master (
        output sb_rd_en, sb_row_sel, sb_pe_sel, id_wr_en, id_wr_data,
        input  sb_id_in, sb_score_in
    );

    modport slave (
        input  sb_rd_en, sb_row_sel, sb_pe_sel, id_wr_en, id_wr_data,
        output sb_id_in, sb_score_in
    );

endinterface

// File: rtl/oflow_cr_owner_table.sv
// Ownership table: one entry per ID recording which bbox currently holds it
// and with what score.
//   clk, reset_N : clock, async active-low reset
//   clr          : clears every valid bit in one cycle (takes priority over we)
//   rd_addr      : combinational read address -> rd_entry
//   we, wr_addr, wr_entry : synchronous write port
// Valid bits live in a flat vector so they can be cleared at once; the
// payload is plain storage and is only meaningful while its valid bit is set.
module oflow_cr_owner_table
    import oflow_cr_pkg::*;
(
    input  logic            clk,
    input  logic            reset_N,
    input  logic            clr,
    input  logic [ID_W-1:0] rd_addr,
    output owner_entry_t    rd_entry,
    input  logic            we,
    input  logic [ID_W-1:0] wr_addr,
    input  owner_entry_t    wr_entry
);

    logic [TBL_DEPTH-1:0] valid_q;
    logic [7:0]           owner_q [TBL_DEPTH];
    logic [SCORE_W-1:0]   score_q [TBL_DEPTH];

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            valid_q <= '0;
        end else if (clr) begin
            valid_q <= '0;
        end else if (we) begin
            valid_q[wr_addr] <= wr_entry.valid;
        end
    end

    always_ff @(posedge clk) begin
        if (we) begin
            owner_q[wr_addr] <= wr_entry.owner;
            score_q[wr_addr] <= wr_entry.score;
        end
    end

    assign rd_entry.valid = valid_q[rd_addr];
    assign rd_entry.owner = owner_q[rd_addr];
    assign rd_entry.score = score_q[rd_addr];

endmodule

// File: rtl/oflow_core_fsm_cr.sv
// Conflict-resolution sequencer. After registration every bbox has a
// candidate ID and score in the score board. Pass 1 (SCAN) reads them all
// and builds an ownership table: the highest score keeps an ID (ties go to
// the lower index) and every other claimant, plus any bbox with ID 0, is
// marked as a loser. Pass 2 (WB) re-reads each bbox and writes back either
// its own ID or a fresh one from new_id_ctr.
//   clk, reset_N          : clock, async active-low reset
//   start_cr              : start pulse (ignored unless IDLE)
//   num_of_bbox_in_frame  : N, 0..256
//   conflict_th           : threshold for conflict_counter_th (0 disables)
//   first_free_id         : seed for fresh IDs
//   sb                    : score-board read/write bus
//   next_free_id          : first unused ID after the run
//   conflict_count        : conflicts found in the last run (saturating)
//   conflict_counter_th   : conflict_count >= conflict_th, conflict_th != 0
//   busy, done_cr         : status, completion pulse
// Latency is 4N+2 cycles from start_cr to done_cr.
module oflow_core_fsm_cr
    import oflow_cr_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_N,
    input  logic                 start_cr,
    input  logic [CNT_W-1:0]     num_of_bbox_in_frame,
    input  logic [7:0]           conflict_th,
    input  logic [ID_W-1:0]      first_free_id,
    oflow_core_fsm_cr_if.master  sb,
    output logic [ID_W-1:0]      next_free_id,
    output logic [CNT_W-1:0]     conflict_count,
    output logic                 conflict_counter_th,
    output logic                 busy,
    output logic                 done_cr
);

    cr_state_e             state_q, state_d;
    logic [CNT_W-1:0]      n_q;
    logic [CNT_W-1:0]      idx_q;
    logic [ROW_W-1:0]      row_q;
    logic [PE_W-1:0]       pe_q;
    logic [ID_W-1:0]       new_id_q;
    logic [MAX_BBOX-1:0]   loser_q;
    logic                  rd_en_q;
    logic                  wr_en_q;

    logic [CNT_W-1:0]      idx_nxt;
    logic                  last;
    logic [ROW_W-1:0]      row_nxt;
    logic [PE_W-1:0]       pe_nxt;

    owner_entry_t          tbl_rd;
    owner_entry_t          tbl_wr;
    logic                  tbl_we;
    logic                  tbl_clr;
    logic                  cur_loser;

    // Index walk: pe wraps at PE_NUM-1 and carries into row, so (row, pe)
    // tracks (i / PE_NUM, i % PE_NUM) without a divider.
    always_comb begin
        idx_nxt = idx_q + CNT_W'(1);
        last    = (idx_nxt == n_q);
        if (pe_q == PE_W'(PE_NUM - 1)) begin
            pe_nxt  = '0;
            row_nxt = row_q + ROW_W'(1);
        end else begin
            pe_nxt  = pe_q + PE_W'(1);
            row_nxt = row_q;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (start_cr) state_d = (num_of_bbox_in_frame == '0) ? DONE : SCAN_RD;
            SCAN_RD:  state_d = SCAN_CMP;
            SCAN_CMP: state_d = last ? WB_RD : SCAN_RD;
            WB_RD:    state_d = WB_WR;
            WB_WR:    state_d = last ? DONE : WB_RD;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // The incoming bbox takes (or keeps) the table entry when its ID is
    // unclaimed or it strictly beats the incumbent.
    always_comb begin
        tbl_clr      = (state_q == IDLE) && start_cr;
        tbl_we       = (state_q == SCAN_CMP) && (sb.sb_id_in != '0) &&
                       (!tbl_rd.valid || (sb.sb_score_in > tbl_rd.score));
        tbl_wr.valid = 1'b1;
        tbl_wr.owner = idx_q[7:0];
        tbl_wr.score = sb.sb_score_in;
    end

    oflow_cr_owner_table u_owner_table (
        .clk      (clk),
        .reset_N  (reset_N),
        .clr      (tbl_clr),
        .rd_addr  (sb.sb_id_in),
        .rd_entry (tbl_rd),
        .we       (tbl_we),
        .wr_addr  (sb.sb_id_in),
        .wr_entry (tbl_wr)
    );

    assign cur_loser = loser_q[idx_q[7:0]];

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            state_q             <= IDLE;
            n_q                 <= '0;
            idx_q               <= '0;
            row_q               <= '0;
            pe_q                <= '0;
            new_id_q            <= '0;
            loser_q             <= '0;
            rd_en_q             <= 1'b0;
            wr_en_q             <= 1'b0;
            busy                <= 1'b0;
            done_cr             <= 1'b0;
            next_free_id        <= '0;
            conflict_count      <= '0;
            conflict_counter_th <= 1'b0;
        end else begin
            state_q <= state_d;
            // Strobes decode the state being entered so they line up with it.
            rd_en_q <= (state_d == SCAN_RD) || (state_d == WB_RD);
            wr_en_q <= (state_d == WB_WR);
            busy    <= (state_d != IDLE);
            done_cr <= (state_q == DONE);

            case (state_q)
                IDLE: begin
                    if (start_cr) begin
                        n_q                 <= num_of_bbox_in_frame;
                        new_id_q            <= first_free_id;
                        conflict_count      <= '0;
                        conflict_counter_th <= 1'b0;
                        loser_q             <= '0;
                        idx_q               <= '0;
                        row_q               <= '0;
                        pe_q                <= '0;
                    end
                end
                SCAN_CMP: begin
                    if (sb.sb_id_in == '0) begin
                        loser_q[idx_q[7:0]] <= 1'b1;
                    end else if (tbl_rd.valid) begin
                        if (sb.sb_score_in > tbl_rd.score)
                            loser_q[tbl_rd.owner] <= 1'b1;
                        else
                            loser_q[idx_q[7:0]] <= 1'b1;
                        if (conflict_count != '1)
                            conflict_count <= conflict_count + CNT_W'(1);
                    end
                    if (last) begin
                        idx_q <= '0;
                        row_q <= '0;
                        pe_q  <= '0;
                    end else begin
                        idx_q <= idx_nxt;
                        row_q <= row_nxt;
                        pe_q  <= pe_nxt;
                    end
                end
                WB_WR: begin
                    if (cur_loser)
                        new_id_q <= id_inc(new_id_q);
                    if (last) begin
                        idx_q <= '0;
                        row_q <= '0;
                        pe_q  <= '0;
                    end else begin
                        idx_q <= idx_nxt;
                        row_q <= row_nxt;
                        pe_q  <= pe_nxt;
                    end
                end
                DONE: begin
                    conflict_counter_th <= (conflict_th != 8'd0) &&
                                           (conflict_count >= {1'b0, conflict_th});
                    next_free_id        <= new_id_q;
                end
                default: ;
            endcase
        end
    end

    assign sb.sb_rd_en   = rd_en_q;
    assign sb.sb_row_sel = row_q;
    assign sb.sb_pe_sel  = pe_q;
    assign sb.id_wr_en   = wr_en_q;
    assign sb.id_wr_data = (state_q == WB_WR) ? (cur_loser ? new_id_q : sb.sb_id_in) : '0;

endmodule
